memory_access_stage: RTL
========================

// Module: memory_access_stage
// PURPOSE
//  MEM stage of the 5-stage core: receiving end of execute_memory_if. Accepts ALU result,
//  store data, opcode, funct3 and rd from EX; drives a req/gnt/rvalid data-memory port
//  for loads and stores, aligns store lanes and sign/zero-extends load data, and
//  presents a registered result to WB through a valid/ready handshake.
// PARAMETERS
//  N  32  datapath width; only 32 supported (byte lanes fixed at 4)
// PORTS
//  clk            in   1   single clock
//  rst_n          in   1   asynchronous active-low reset
//  em_valid       in   1   EX result valid
//  em_ready       out  1   stage can accept
//  em_alu_result  in   N   ALU result / effective address
//  em_rs2_data    in   N   store data
//  em_opcode      in   7   opcode_t from riscv_pkg
//  em_funct3      in   3   access size/sign (new execute_memory_if field)
//  em_rd          in   5   destination register
//  dmem_req       out  1   memory request
//  dmem_we        out  1   1=store
//  dmem_addr      out  N   word address {ea[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  N   lane-aligned store data
//  dmem_gnt       in   1   request accepted
//  dmem_rvalid    in   1   load data valid
//  dmem_rdata     in   N   load word
//  mw_valid       out  1   WB result valid
//  mw_ready       in   1   WB accepts
//  mw_rd          out  5   destination register
//  mw_data        out  N   writeback data
//  mw_reg_write   out  1   write rd (0 for store/branch/rd==x0/misaligned)
//  mw_misaligned  out  1   access was misaligned, not performed
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (em_ready then rises combinationally).
//  FSM states IDLE, MEM_REQ, MEM_WAIT.
//  em_ready = (state==IDLE) && (!mw_valid || mw_ready). Accept = em_valid && em_ready;
//   inputs captured into internal regs on accept.
//  IDLE, accept, non-memory opcode: next cycle mw_valid=1, mw_data=alu_result;
//   reg_write=1 for REG_REG/REG_IMM/JAL/JALR with rd!=0, 0 for BRANCH/unknown. Latency 1.
//  IDLE, accept, LOAD/STORE misaligned (H: ea[0]!=0; W: ea[1:0]!=0): no request;
//   next cycle mw_valid=1, mw_misaligned=1, reg_write=0.
//  IDLE, accept, aligned LOAD/STORE -> MEM_REQ. dmem_req=1 only in MEM_REQ; addr/we/be/wdata
//   held stable until dmem_gnt.
//  MEM_REQ & gnt: store -> IDLE, mw_valid=1, reg_write=0; load -> MEM_WAIT.
//  MEM_WAIT & dmem_rvalid -> IDLE, mw_valid=1, data extracted. rvalid never coincides with
//   gnt. rvalid outside MEM_WAIT is ignored.
//  Store lanes: SB be=4'b0001<<ea[1:0], wdata={4{rs2[7:0]}}; SH be=4'b0011<<{ea[1],1'b0},
//   wdata={2{rs2[15:0]}}; SW be=4'hF, wdata=rs2.
//  Load extract: LB/LBU byte ea[1:0], sign/zero-extend; LH/LHU half ea[1]; LW full word.
//   Unsupported funct3 is treated as misaligned.
//  mw_* regs hold while mw_valid && !mw_ready; mw_valid clears on handshake with no new
//   result. Back-to-back ALU ops sustain 1/cycle when mw_ready=1.
//  Reset mid-access: drop dmem_req and mw_valid immediately; a late rvalid is ignored.
// STRUCTURE
//  riscv_pkg additions: F3_LB/LH/LW/LBU/LHU, F3_SB/SH/SW, mem_state_e {IDLE,MEM_REQ,MEM_WAIT}.
//  Sub-module load_store_align (combinational): ea[1:0], funct3, rs2, rdata ->
//   be, wdata, load_data, misaligned.
//  Top holds FSM, capture regs and output regs.
// TESTING
//  ADD, alu_result=0x1234, rd=5, mw_ready=1 -> next cycle mw_valid, data=0x1234, reg_write=1.
//  SB ea=0x103, rs2=0xAB, gnt after 2 cycles -> be=4'b1000, wdata=0xABABABAB,
//   addr=0x100 held stable, mw_reg_write=0.
//  LB ea=0x102, rdata=0x00800000 -> mw_data=0xFFFFFF80; LBU -> 0x00000080.
//  LW ea=0x202 -> no dmem_req, mw_misaligned=1, mw_reg_write=0.
//  mw_ready=0 for 3 cycles with result pending -> em_ready=0, mw_data stable; release ->
//   next op accepted.
//  rst_n low in MEM_WAIT, then rvalid -> dmem_req=0, mw_valid=0, rvalid ignored, state IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode, funct3 and MEM-stage FSM definitions
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD    = 7'b0000011,
    OP_REG_IMM = 7'b0010011,
    OP_STORE   = 7'b0100011,
    OP_REG_REG = 7'b0110011,
    OP_BRANCH  = 7'b1100011,
    OP_JALR    = 7'b1100111,
    OP_JAL     = 7'b1101111
  } opcode_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_e;

  // Non-memory opcodes that produce a register result.
  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_REG_REG, OP_REG_IMM, OP_JAL, OP_JALR: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering for stores and extraction for loads
module load_store_align
  import riscv_pkg::*;
(
  input  logic [1:0]  ea_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    lb           = rdata_i[{ea_i, 3'b000} +: 8];
    lh           = ea_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o         = 4'b0000;
    wdata_o      = '0;
    load_data_o  = '0;
    misaligned_o = 1'b0;
    if (is_store_i) begin
      case (funct3_i)
        F3_SB: begin
          be_o    = 4'b0001 << ea_i;
          wdata_o = {4{rs2_i[7:0]}};
        end
        F3_SH: begin
          be_o         = 4'b0011 << {ea_i[1], 1'b0};
          wdata_o      = {2{rs2_i[15:0]}};
          misaligned_o = ea_i[0];
        end
        F3_SW: begin
          be_o         = 4'b1111;
          wdata_o      = rs2_i;
          misaligned_o = |ea_i;
        end
        default: misaligned_o = 1'b1;
      endcase
    end else begin
      // Unsupported load widths are reported as misaligned so no access is made.
      case (funct3_i)
        F3_LB: begin
          be_o        = 4'b0001 << ea_i;
          load_data_o = {{24{lb[7]}}, lb};
        end
        F3_LBU: begin
          be_o        = 4'b0001 << ea_i;
          load_data_o = {24'b0, lb};
        end
        F3_LH: begin
          be_o         = 4'b0011 << {ea_i[1], 1'b0};
          load_data_o  = {{16{lh[15]}}, lh};
          misaligned_o = ea_i[0];
        end
        F3_LHU: begin
          be_o         = 4'b0011 << {ea_i[1], 1'b0};
          load_data_o  = {16'b0, lh};
          misaligned_o = ea_i[0];
        end
        F3_LW: begin
          be_o         = 4'b1111;
          load_data_o  = rdata_i;
          misaligned_o = |ea_i;
        end
        default: misaligned_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM stage: data-memory port FSM and registered WB result
module memory_access_stage
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         em_valid,
  output logic         em_ready,
  input  logic [N-1:0] em_alu_result,
  input  logic [N-1:0] em_rs2_data,
  input  logic [6:0]   em_opcode,
  input  logic [2:0]   em_funct3,
  input  logic [4:0]   em_rd,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [3:0]   dmem_be,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_gnt,
  input  logic         dmem_rvalid,
  input  logic [N-1:0] dmem_rdata,
  output logic         mw_valid,
  input  logic         mw_ready,
  output logic [4:0]   mw_rd,
  output logic [N-1:0] mw_data,
  output logic         mw_reg_write,
  output logic         mw_misaligned
);

  mem_state_e  state_q, state_d;
  logic [N-1:0] ea_q, ea_d, rs2_q, rs2_d;
  logic [2:0]   f3_q, f3_d;
  logic [4:0]   rd_q, rd_d;
  logic         store_q, store_d;
  logic         mw_valid_q, mw_valid_d, mw_rw_q, mw_rw_d, mw_mis_q, mw_mis_d;
  logic [4:0]   mw_rd_q, mw_rd_d;
  logic [N-1:0] mw_data_q, mw_data_d;

  logic         idle, accept, in_load, in_store, in_mem;
  logic [1:0]   al_ea;
  logic [2:0]   al_f3;
  logic         al_store, al_mis;
  logic [3:0]   al_be;
  logic [31:0]  al_wdata, al_load;

  assign idle     = (state_q == IDLE);
  assign em_ready = idle && (!mw_valid_q || mw_ready);
  assign accept   = em_valid && em_ready;
  assign in_load  = (em_opcode == OP_LOAD);
  assign in_store = (em_opcode == OP_STORE);
  assign in_mem   = in_load || in_store;

  // In IDLE the aligner judges the incoming op; afterwards it serves the captured one.
  assign al_ea    = idle ? em_alu_result[1:0] : ea_q[1:0];
  assign al_f3    = idle ? em_funct3 : f3_q;
  assign al_store = idle ? in_store : store_q;

  load_store_align u_align (
    .ea_i        (al_ea),
    .funct3_i    (al_f3),
    .is_store_i  (al_store),
    .rs2_i       (rs2_q),
    .rdata_i     (dmem_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .load_data_o (al_load),
    .misaligned_o(al_mis)
  );

  assign dmem_req   = (state_q == MEM_REQ);
  assign dmem_we    = dmem_req && store_q;
  assign dmem_addr  = dmem_req ? {ea_q[N-1:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? al_be : 4'b0000;
  assign dmem_wdata = dmem_we ? al_wdata : '0;

  assign mw_valid      = mw_valid_q;
  assign mw_rd         = mw_rd_q;
  assign mw_data       = mw_data_q;
  assign mw_reg_write  = mw_rw_q;
  assign mw_misaligned = mw_mis_q;

  always_comb begin
    state_d    = state_q;
    ea_d       = ea_q;
    rs2_d      = rs2_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    store_d    = store_q;
    mw_valid_d = mw_valid_q && !mw_ready;
    mw_rd_d    = mw_rd_q;
    mw_data_d  = mw_data_q;
    mw_rw_d    = mw_rw_q;
    mw_mis_d   = mw_mis_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ea_d    = em_alu_result;
          rs2_d   = em_rs2_data;
          f3_d    = em_funct3;
          rd_d    = em_rd;
          store_d = in_store;
          mw_rd_d = em_rd;
          if (in_mem && !al_mis) begin
            state_d = MEM_REQ;
          end else begin
            mw_valid_d = 1'b1;
            mw_data_d  = em_alu_result;
            mw_mis_d   = in_mem;
            mw_rw_d    = !in_mem && writes_rd(em_opcode) && (em_rd != 5'd0);
          end
        end
      end
      MEM_REQ: begin
        if (dmem_gnt) begin
          if (store_q) begin
            state_d    = IDLE;
            mw_valid_d = 1'b1;
            mw_data_d  = ea_q;
            mw_rw_d    = 1'b0;
            mw_mis_d   = 1'b0;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_rvalid) begin
          state_d    = IDLE;
          mw_valid_d = 1'b1;
          mw_data_d  = al_load;
          mw_rw_d    = (rd_q != 5'd0);
          mw_mis_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ea_q       <= '0;
      rs2_q      <= '0;
      f3_q       <= 3'd0;
      rd_q       <= 5'd0;
      store_q    <= 1'b0;
      mw_valid_q <= 1'b0;
      mw_rd_q    <= 5'd0;
      mw_data_q  <= '0;
      mw_rw_q    <= 1'b0;
      mw_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ea_q       <= ea_d;
      rs2_q      <= rs2_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      store_q    <= store_d;
      mw_valid_q <= mw_valid_d;
      mw_rd_q    <= mw_rd_d;
      mw_data_q  <= mw_data_d;
      mw_rw_q    <= mw_rw_d;
      mw_mis_q   <= mw_mis_d;
    end
  end

endmodule
